// File: rtl/pcie_scr_pkg.sv
// Shared constants, block classification and width decode for the PIPE TX scrambler.
// Both LFSRs are Galois form: output bit is the MSB, feedback taps are XORed in after the shift.
package pcie_scr_pkg;

  localparam logic [7:0]  COM_K       = 8'hBC;
  localparam logic [7:0]  SKP_K       = 8'h1C;
  localparam logic [15:0] LFSR16_SEED = 16'hFFFF;

  localparam logic [1:0]  SH_DATA = 2'b01;
  localparam logic [1:0]  SH_OS   = 2'b10;

  localparam logic [7:0]  OS_TS1   = 8'h1E;
  localparam logic [7:0]  OS_TS2   = 8'h2D;
  localparam logic [7:0]  OS_SKP   = 8'hAA;
  localparam logic [7:0]  OS_EIEOS = 8'h00;
  localparam logic [7:0]  OS_EIOS  = 8'h66;
  localparam logic [7:0]  OS_FTS   = 8'h55;
  localparam logic [7:0]  OS_SDS   = 8'hE1;

  // x^16+x^5+x^4+x^3+1 and x^23+x^21+x^16+x^8+x^5+x^2+1, x^0 term included
  localparam logic [15:0] LFSR16_TAPS = 16'h0039;
  localparam logic [22:0] LFSR23_TAPS = 23'h210125;

  typedef enum logic [2:0] {
    BLK_DATA,
    BLK_TS,
    BLK_SKP,
    BLK_EIEOS,
    BLK_OTHER
  } blk_type_e;

  function automatic blk_type_e blk_classify(input logic [1:0] sh, input logic [7:0] sym0);
    if (sh == SH_DATA) return BLK_DATA;
    if (sh != SH_OS)   return BLK_OTHER;
    case (sym0)
      OS_TS1, OS_TS2:          return BLK_TS;
      OS_SKP:                  return BLK_SKP;
      OS_EIEOS:                return BLK_EIEOS;
      OS_EIOS, OS_FTS, OS_SDS: return BLK_OTHER;
      default:                 return BLK_OTHER;
    endcase
  endfunction

  function automatic logic [2:0] lanes_from_width(input logic [5:0] w);
    case (w)
      6'd8:    return 3'd1;
      6'd16:   return 3'd2;
      6'd32:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_scr_lfsr_byte.sv
// One-byte combinational LFSR step: eight Galois shifts, emitting the scramble byte LSB first.
// In 16-bit mode only state[15:0] is meaningful and the upper bits come out zero.
module pipe_scr_lfsr_byte
  import pcie_scr_pkg::*;
(
  input  logic        i_mode23,
  input  logic [22:0] i_state,
  output logic [22:0] o_state,
  output logic [7:0]  o_key
);

  logic [22:0] w_s;

  always_comb begin
    w_s   = i_state;
    o_key = '0;
    for (int b = 0; b < 8; b++) begin
      if (i_mode23) begin
        o_key[b] = w_s[22];
        w_s      = {w_s[21:0], 1'b0} ^ (w_s[22] ? LFSR23_TAPS : 23'd0);
      end else begin
        o_key[b] = w_s[15];
        w_s      = {7'd0, w_s[14:0], 1'b0} ^ (w_s[15] ? {7'd0, LFSR16_TAPS} : 23'd0);
      end
    end
    o_state = w_s;
  end

endmodule

// File: rtl/pipe_tx_scrambler.sv
// PCIe MAC TX scrambler in front of the PIPE TX interface: 8b/10b (Gen1/2) and 128b/130b (Gen3+)
// rules, up to four symbols per PCLK, one registered stage.
module pipe_tx_scrambler
  import pcie_scr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  GEN,
  input  logic [5:0]  PIPEWIDTH,
  input  logic        turnOff,
  input  logic [23:0] seedValue,
  input  logic        macDataValid,
  input  logic        macStartBlock,
  input  logic [1:0]  macSyncHeader,
  input  logic [31:0] macData,
  input  logic [3:0]  macDataK,
  output logic        PIPETxDataValid,
  output logic        PIPETxStartBlock,
  output logic [1:0]  PIPETxSyncHeader,
  output logic [31:0] PIPETxData,
  output logic [3:0]  PIPETxDataK
);

  localparam int NUM_LANES = 4;

  logic [15:0] r_lfsr16;
  logic [22:0] r_lfsr23;
  logic [3:0]  r_sym;
  blk_type_e   r_blk;
  logic [2:0]  r_gen;
  logic [5:0]  r_width;

  logic        w_gen3, w_width_ok, w_adv, w_reload, w_cap;
  logic [2:0]  w_nlanes;
  logic [15:0] w_s16;
  logic [22:0] w_s23;
  logic [3:0]  w_sym0;
  blk_type_e   w_blk_in, w_blk;
  logic [22:0] w_st [NUM_LANES+1];
  logic [7:0]  w_byte_out [NUM_LANES];
  logic [31:0] w_data_out;
  logic        w_unused;

  assign w_unused   = seedValue[23];
  assign w_gen3     = (GEN >= 3'd3);
  assign w_nlanes   = lanes_from_width(PIPEWIDTH);
  assign w_width_ok = (w_nlanes != 3'd0);
  assign w_adv      = macDataValid && w_width_ok;

  // A rate or width change restarts both scramblers; the beat on that edge already uses the fresh state.
  assign w_reload = (GEN != r_gen) || (macDataValid && (PIPEWIDTH != r_width));
  assign w_s16    = w_reload ? LFSR16_SEED : r_lfsr16;
  assign w_s23    = w_reload ? seedValue[22:0] : r_lfsr23;
  assign w_sym0   = (w_reload || (macDataValid && macStartBlock)) ? 4'd0 : r_sym;
  assign w_blk_in = w_reload ? BLK_DATA : r_blk;

  // A SKP block runs until the next explicit start, so a symbol-counter wrap does not reclassify it.
  assign w_cap = (w_sym0 == 4'd0) && (macStartBlock || (w_blk_in != BLK_SKP));
  assign w_blk = w_cap ? blk_classify(macSyncHeader, macData[7:0]) : w_blk_in;

  assign w_st[0] = w_gen3 ? w_s23 : {7'd0, w_s16};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [22:0] w_adv_st, w_nxt;
    logic [7:0]  w_key, w_b;
    logic [3:0]  w_symi;
    logic        w_act, w_k, w_scr;

    pipe_scr_lfsr_byte u_step (
      .i_mode23 (w_gen3),
      .i_state  (w_st[g]),
      .o_state  (w_adv_st),
      .o_key    (w_key)
    );

    assign w_b    = macData[8*g +: 8];
    assign w_k    = macDataK[g];
    assign w_symi = w_sym0 + 4'(g);
    assign w_act  = (3'(g) < w_nlanes);

    always_comb begin
      w_scr = 1'b0;
      w_nxt = w_adv_st;
      if (w_gen3) begin
        w_scr = (w_blk == BLK_DATA) || ((w_blk == BLK_TS) && (w_symi != 4'd0));
        if (w_blk == BLK_SKP)
          w_nxt = w_st[g];
        else if ((w_blk == BLK_EIEOS) && (w_symi == 4'd15))
          w_nxt = seedValue[22:0];
      end else begin
        w_scr = !w_k && !turnOff;
        if (w_k && (w_b == COM_K))
          w_nxt = {7'd0, LFSR16_SEED};
        else if (w_k && (w_b == SKP_K))
          w_nxt = w_st[g];
      end
      if (!w_act) begin
        w_scr = 1'b0;
        w_nxt = w_st[g];
      end
    end

    assign w_st[g+1]     = w_nxt;
    assign w_byte_out[g] = !w_act ? 8'd0 : (w_scr ? (w_b ^ w_key) : w_b);
  end

  assign w_data_out = {w_byte_out[3], w_byte_out[2], w_byte_out[1], w_byte_out[0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lfsr16         <= LFSR16_SEED;
      r_lfsr23         <= seedValue[22:0];
      r_sym            <= 4'd0;
      r_blk            <= BLK_DATA;
      r_gen            <= GEN;
      r_width          <= PIPEWIDTH;
      PIPETxDataValid  <= 1'b0;
      PIPETxStartBlock <= 1'b0;
      PIPETxSyncHeader <= 2'b00;
      PIPETxData       <= 32'd0;
      PIPETxDataK      <= 4'd0;
    end else begin
      r_gen <= GEN;
      if (macDataValid) r_width <= PIPEWIDTH;
      r_lfsr16 <= (w_adv && !w_gen3) ? w_st[NUM_LANES][15:0] : w_s16;
      r_lfsr23 <= (w_adv &&  w_gen3) ? w_st[NUM_LANES]       : w_s23;
      r_sym    <= w_adv ? (w_sym0 + {1'b0, w_nlanes}) : w_sym0;
      r_blk    <= w_adv ? w_blk : w_blk_in;
      PIPETxDataValid  <= macDataValid;
      PIPETxStartBlock <= macStartBlock;
      PIPETxSyncHeader <= macSyncHeader;
      PIPETxData       <= w_adv ? w_data_out : 32'd0;
      PIPETxDataK      <= macDataK;
    end
  end

endmodule
